// File: rtl/down_counter_timer.sv
// Loadable WIDTH-bit countdown timer with one-shot / auto-reload modes and a one-cycle tc pulse.
// Optional prescaler enabled by defining TIMER_PRESCALE_EN (PRESCALE en-cycles per decrement).
module down_counter_timer #(
    parameter int WIDTH    = 4,
    parameter int PRESCALE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done,
    output logic             tc
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] reload_reg;
    logic             mode;
    logic             step;

    if (PRESCALE < 1) begin : g_prescale_check
        $error("down_counter_timer: PRESCALE must be >= 1");
    end

`ifdef TIMER_PRESCALE_EN
    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

    logic [PRE_W-1:0] pre_cnt;

    assign step = en && (pre_cnt == PRE_LAST);

    // Prescaler only advances while counting; a load restarts the period from scratch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt <= '0;
        end else if (load) begin
            pre_cnt <= '0;
        end else if (state == RUN && en) begin
            if (step) begin
                pre_cnt <= '0;
            end else begin
                pre_cnt <= pre_cnt + PRE_W'(1);
            end
        end
    end
`else
    assign step = en;
`endif

    // busy/done are registered alongside state so they always mirror it exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            q          <= '0;
            reload_reg <= '0;
            mode       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            tc         <= 1'b0;
        end else begin
            tc <= 1'b0;
            if (load) begin
                q          <= load_val;
                reload_reg <= load_val;
                mode       <= auto_reload;
                done       <= 1'b0;
                if (load_val != '0) begin
                    state <= RUN;
                    busy  <= 1'b1;
                end else begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            end else begin
                case (state)
                    RUN: begin
                        if (step) begin
                            if (q > WIDTH'(1)) begin
                                q <= q - WIDTH'(1);
                            end else if (mode) begin
                                // Periodic: jump straight to the reload value, 0 is never shown.
                                q  <= reload_reg;
                                tc <= 1'b1;
                            end else begin
                                q     <= '0;
                                tc    <= 1'b1;
                                state <= DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_down_counter_timer.sv
// Bench for down_counter_timer: hand-derived vector table, async reset checks and
// randomized traffic compared against a behavioural countdown model.
module tb_down_counter_timer;

    localparam int WIDTH    = 4;
    localparam int PRESCALE = 4;
`ifdef TIMER_PRESCALE_EN
    localparam int PS = PRESCALE;
`else
    localparam int PS = 1;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             en = 1'b0;
    logic             load = 1'b0;
    logic [WIDTH-1:0] load_val = '0;
    logic             auto_reload = 1'b0;
    logic [WIDTH-1:0] q;
    logic             busy;
    logic             done;
    logic             tc;

    down_counter_timer #(.WIDTH(WIDTH), .PRESCALE(PRESCALE)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .load(load), .load_val(load_val),
        .auto_reload(auto_reload), .q(q), .busy(busy), .done(done), .tc(tc)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model: remaining count, phase (0 idle / 1 counting / 2 expired), en-cycles so far.
    int m_q, m_phase, m_reload, m_mode, m_pre, m_tc;

    task automatic model_reset();
        m_q = 0; m_phase = 0; m_reload = 0; m_mode = 0; m_pre = 0; m_tc = 0;
    endtask

    task automatic model_edge(input int l, input int e, input int lv, input int ar);
        m_tc = 0;
        if (l != 0) begin
            m_q = lv; m_reload = lv; m_mode = ar; m_pre = 0;
            m_phase = (lv != 0) ? 1 : 0;
        end else if (m_phase == 1 && e != 0) begin
            m_pre = m_pre + 1;
            if (m_pre == PS) begin
                m_pre = 0;
                if (m_q > 1) begin
                    m_q = m_q - 1;
                end else begin
                    m_tc = 1;
                    if (m_mode != 0) m_q = m_reload;
                    else begin
                        m_q = 0;
                        m_phase = 2;
                    end
                end
            end
        end
    endtask

    task automatic check_sig(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input int eq, input int eb, input int ed, input int et);
        check_sig({tag, ".q"}, int'(q), eq);
        check_sig({tag, ".busy"}, int'(busy), eb);
        check_sig({tag, ".done"}, int'(done), ed);
        check_sig({tag, ".tc"}, int'(tc), et);
    endtask

    task automatic cycle(input logic l, input logic e, input logic [WIDTH-1:0] lv, input logic ar);
        load = l; en = e; load_val = lv; auto_reload = ar;
        @(posedge clk);
        model_edge(int'(l), int'(e), int'(lv), int'(ar));
        #1;
        check_all("model", m_q, int'(m_phase == 1), int'(m_phase == 2), m_tc);
    endtask

    typedef struct {
        logic             load;
        logic             en;
        logic [WIDTH-1:0] lv;
        logic             ar;
        logic [WIDTH-1:0] eq;
        logic             eb;
        logic             ed;
        logic             et;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic l, input logic e, input int lv, input logic ar,
                                input int eq, input logic eb, input logic ed, input logic et);
        vec_t v;
        v.load = l; v.en = e; v.lv = WIDTH'(lv); v.ar = ar;
        v.eq = WIDTH'(eq); v.eb = eb; v.ed = ed; v.et = et;
        vecs.push_back(v);
    endfunction

    initial begin
        // One-shot 5 down to 0, then parked in DONE.
        add(1, 1, 5, 0, 5, 1, 0, 0);
        add(0, 1, 0, 0, 4, 1, 0, 0);
        add(0, 1, 0, 0, 3, 1, 0, 0);
        add(0, 1, 0, 0, 2, 1, 0, 0);
        add(0, 1, 0, 0, 1, 1, 0, 0);
        add(0, 1, 0, 0, 0, 0, 1, 1);
        add(0, 1, 0, 0, 0, 0, 1, 0);
        add(0, 1, 0, 0, 0, 0, 1, 0);
        // Periodic 3,2,1,3,... with tc on each reload.
        add(1, 1, 3, 1, 3, 1, 0, 0);
        add(0, 1, 0, 0, 2, 1, 0, 0);
        add(0, 1, 0, 0, 1, 1, 0, 0);
        add(0, 1, 0, 0, 3, 1, 0, 1);
        add(0, 1, 0, 0, 2, 1, 0, 0);
        add(0, 1, 0, 0, 1, 1, 0, 0);
        add(0, 1, 0, 0, 3, 1, 0, 1);
        add(0, 1, 0, 0, 2, 1, 0, 0);
        // Pause/resume.
        add(1, 0, 4, 0, 4, 1, 0, 0);
        add(0, 1, 0, 0, 3, 1, 0, 0);
        add(0, 1, 0, 0, 2, 1, 0, 0);
        add(0, 0, 0, 0, 2, 1, 0, 0);
        add(0, 0, 0, 0, 2, 1, 0, 0);
        add(0, 0, 0, 0, 2, 1, 0, 0);
        add(0, 1, 0, 0, 1, 1, 0, 0);
        add(0, 1, 0, 0, 0, 0, 1, 1);
        add(0, 1, 0, 0, 0, 0, 1, 0);
        // Restart mid-count, load of zero, IDLE ignores en, load beats the final step.
        add(1, 0, 4, 0, 4, 1, 0, 0);
        add(0, 1, 0, 0, 3, 1, 0, 0);
        add(0, 1, 0, 0, 2, 1, 0, 0);
        add(1, 1, 9, 0, 9, 1, 0, 0);
        add(0, 1, 0, 0, 8, 1, 0, 0);
        add(1, 1, 0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 0, 0);
        add(1, 1, 2, 0, 2, 1, 0, 0);
        add(0, 1, 0, 0, 1, 1, 0, 0);
        add(1, 1, 3, 0, 3, 1, 0, 0);
        add(0, 1, 0, 0, 2, 1, 0, 0);
        // A load while DONE leaves DONE.
        add(0, 1, 0, 0, 1, 1, 0, 0);
        add(0, 1, 0, 0, 0, 0, 1, 1);
        add(1, 0, 6, 1, 6, 1, 0, 0);

        model_reset();
        #30;
        check_all("reset", 0, 0, 0, 0);
        rst_n = 1'b1;

`ifndef TIMER_PRESCALE_EN
        foreach (vecs[i]) begin
            load = vecs[i].load; en = vecs[i].en; load_val = vecs[i].lv; auto_reload = vecs[i].ar;
            @(posedge clk);
            model_edge(int'(vecs[i].load), int'(vecs[i].en), int'(vecs[i].lv), int'(vecs[i].ar));
            #1;
            check_all($sformatf("vec%0d", i), int'(vecs[i].eq), int'(vecs[i].eb),
                      int'(vecs[i].ed), int'(vecs[i].et));
        end
`endif

        // Asynchronous reset in the middle of a count, between clock edges.
        cycle(1'b1, 1'b0, WIDTH'(9), 1'b0);
        cycle(1'b0, 1'b1, '0, 1'b0);
        cycle(1'b0, 1'b1, '0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst", 0, 0, 0, 0);
        rst_n = 1'b1;

        // Short and full-range one-shot runs (prescaled when the feature is built in).
        cycle(1'b1, 1'b1, WIDTH'(2), 1'b0);
        repeat (10) cycle(1'b0, 1'b1, '0, 1'b0);
        cycle(1'b1, 1'b1, WIDTH'(15), 1'b0);
        repeat (70) cycle(1'b0, 1'b1, '0, 1'b0);

        // Randomized traffic.
        repeat (600) begin
            cycle(1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 3) != 0),
                  WIDTH'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
